// File: rtl/ccx_ic_pkg.sv
// Shared types and defaults for the core-complex interconnect QoS arbiter.
package ccx_ic_pkg;

    localparam int unsigned CCX_AW = 39;
    localparam int unsigned CCX_DW = 64;

    typedef logic [0:0] req_id_t;

    localparam req_id_t ID_DATA  = 1'b0;
    localparam req_id_t ID_INSTR = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ccx_ic_order_fifo.sv
// Small synchronous FIFO with full/empty flags; holds requester IDs in grant order.
module ccx_ic_order_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_ok_s, rd_ok_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == {CW{1'b0}});
    assign wr_ok_s = push_i && !full_o;
    assign rd_ok_s = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Occupancy next-state
    always_comb begin
        cnt_d = cnt_q;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_q <= rd_ok_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ccx_ic_qos_arbiter.sv
// Two-requester arbiter for one memory target: data-port priority with an
// instruction-port starvation override, plus in-order response routing.
module ccx_ic_qos_arbiter
    import ccx_ic_pkg::*;
#(
    parameter int unsigned AW          = CCX_AW,
    parameter int unsigned DW          = CCX_DW,
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            r0_req,
    output logic            r0_gnt,
    input  logic            r0_wen,
    input  logic [DW/8-1:0] r0_strb,
    input  logic [AW-1:0]   r0_addr,
    input  logic [DW-1:0]   r0_wdata,
    output logic            r0_recv,
    input  logic            r0_ack,
    output logic            r0_error,
    output logic [DW-1:0]   r0_rdata,
    input  logic            r1_req,
    output logic            r1_gnt,
    input  logic            r1_wen,
    input  logic [DW/8-1:0] r1_strb,
    input  logic [AW-1:0]   r1_addr,
    input  logic [DW-1:0]   r1_wdata,
    output logic            r1_recv,
    input  logic            r1_ack,
    output logic            r1_error,
    output logic [DW-1:0]   r1_rdata,
    output logic            t_req,
    output logic            t_wen,
    output logic [DW/8-1:0] t_strb,
    output logic [AW-1:0]   t_addr,
    output logic [DW-1:0]   t_wdata,
    input  logic            t_gnt,
    input  logic            t_recv,
    input  logic            t_error,
    input  logic [DW-1:0]   t_rdata,
    output logic            t_ack,
    output logic            orphan_rsp
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_e    state_q, state_d;
    req_id_t       sel_q, sel_d, cur_sel_s, head_s;
    logic [SW-1:0] starve_q, starve_d;
    logic          fifo_full_s, fifo_empty_s;
    logic          r0_win_s, r1_win_s, t_req_s, push_s, pop_s;

    assign r0_win_s = r0_req && (starve_q < SW'(STARVE_MAX));
    assign r1_win_s = r1_req && (!r0_req || (starve_q == SW'(STARVE_MAX)));

    // Arbitration / hold FSM next-state
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cur_sel_s = sel_q;
        t_req_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_full_s) begin
                    t_req_s = 1'b0;
                end else if (r0_win_s) begin
                    t_req_s   = 1'b1;
                    cur_sel_s = ID_DATA;
                end else if (r1_win_s) begin
                    t_req_s   = 1'b1;
                    cur_sel_s = ID_INSTR;
                end else begin
                    t_req_s = 1'b0;
                end
                if (t_req_s && !t_gnt) begin
                    state_d = HOLD;
                    sel_d   = cur_sel_s;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                cur_sel_s = sel_q;
                t_req_s   = (sel_q == ID_INSTR) ? r1_req : r0_req;
                // A dropped request abandons the hold without pushing anything.
                if (!t_req_s || t_gnt) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push_s = t_req_s && t_gnt;
    assign t_req  = t_req_s;
    assign r0_gnt = push_s && (cur_sel_s == ID_DATA);
    assign r1_gnt = push_s && (cur_sel_s == ID_INSTR);

    // Request payload pass-through, zeroed when nothing is requested
    always_comb begin
        t_wen   = 1'b0;
        t_strb  = {(DW/8){1'b0}};
        t_addr  = {AW{1'b0}};
        t_wdata = {DW{1'b0}};
        if (t_req_s && (cur_sel_s == ID_INSTR)) begin
            t_wen   = r1_wen;
            t_strb  = r1_strb;
            t_addr  = r1_addr;
            t_wdata = r1_wdata;
        end else if (t_req_s) begin
            t_wen   = r0_wen;
            t_strb  = r0_strb;
            t_addr  = r0_addr;
            t_wdata = r0_wdata;
        end else begin
            t_wen = 1'b0;
        end
    end

    // Response routing to the oldest outstanding requester; orphans are drained
    always_comb begin
        r0_recv    = 1'b0;
        r0_error   = 1'b0;
        r0_rdata   = {DW{1'b0}};
        r1_recv    = 1'b0;
        r1_error   = 1'b0;
        r1_rdata   = {DW{1'b0}};
        t_ack      = 1'b0;
        orphan_rsp = 1'b0;
        if (fifo_empty_s) begin
            t_ack      = t_recv;
            orphan_rsp = t_recv;
        end else if (head_s == ID_INSTR) begin
            r1_recv  = t_recv;
            r1_error = t_error;
            r1_rdata = t_rdata;
            t_ack    = r1_ack;
        end else begin
            r0_recv  = t_recv;
            r0_error = t_error;
            r0_rdata = t_rdata;
            t_ack    = r0_ack;
        end
    end

    assign pop_s = t_recv && t_ack && !fifo_empty_s;

    // Starvation counter next-state
    always_comb begin
        starve_d = starve_q;
        if (push_s && (cur_sel_s == ID_INSTR)) begin
            starve_d = {SW{1'b0}};
        end else if (push_s && r1_req && (starve_q < SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // State, selection and starvation registers
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q  <= IDLE;
            sel_q    <= ID_DATA;
            starve_q <= {SW{1'b0}};
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            starve_q <= starve_d;
        end
    end

    ccx_ic_order_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_order_fifo (
        .clk     (g_clk),
        .rst     (g_reset),
        .push_i  (push_s),
        .wdata_i (cur_sel_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

endmodule

// File: tb/tb_ccx_ic_qos_arbiter.sv
// Randomised and directed bench for ccx_ic_qos_arbiter against a queue-based reference model.
module tb_ccx_ic_qos_arbiter;

    localparam int AW = 39;
    localparam int DW = 64;
    localparam int OUTSTANDING = 2;
    localparam int STARVE_MAX = 4;

    logic g_clk = 1'b0;
    logic g_reset;
    logic r0_req, r0_gnt, r0_wen, r0_recv, r0_ack, r0_error;
    logic r1_req, r1_gnt, r1_wen, r1_recv, r1_ack, r1_error;
    logic [DW/8-1:0] r0_strb, r1_strb, t_strb;
    logic [AW-1:0] r0_addr, r1_addr, t_addr;
    logic [DW-1:0] r0_wdata, r1_wdata, t_wdata, r0_rdata, r1_rdata, t_rdata;
    logic t_req, t_wen, t_gnt, t_recv, t_error, t_ack, orphan_rsp;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state: pending grant order, held requester, starvation count
    int mq[$];
    int m_held = -1;
    int m_sc = 0;
    bit p_push, p_pop, p_treq, p_r1req;
    int p_win;
    bit e_gnt0, e_gnt1;

    always #5 g_clk = ~g_clk;

    ccx_ic_qos_arbiter #(.AW(AW), .DW(DW), .OUTSTANDING(OUTSTANDING), .STARVE_MAX(STARVE_MAX)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_wen(r0_wen), .r0_strb(r0_strb), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_recv(r0_recv), .r0_ack(r0_ack), .r0_error(r0_error), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_wen(r1_wen), .r1_strb(r1_strb), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_recv(r1_recv), .r1_ack(r1_ack), .r1_error(r1_error), .r1_rdata(r1_rdata),
        .t_req(t_req), .t_wen(t_wen), .t_strb(t_strb), .t_addr(t_addr), .t_wdata(t_wdata),
        .t_gnt(t_gnt), .t_recv(t_recv), .t_error(t_error), .t_rdata(t_rdata), .t_ack(t_ack),
        .orphan_rsp(orphan_rsp)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: derive every output from the arbitration rules, compare each cycle
    int win, head;
    bit full, empty, treq, e_ack;
    logic [63:0] e_addr, e_wdata, e_strb, e_wen;
    always @(negedge g_clk) begin
        if (g_reset) begin
            p_push = 1'b0; p_pop = 1'b0; p_treq = 1'b0; e_gnt0 = 1'b0; e_gnt1 = 1'b0;
        end else begin
            full  = (mq.size() == OUTSTANDING);
            empty = (mq.size() == 0);
            win = -1;
            if (m_held >= 0) begin
                win  = m_held;
                treq = (m_held == 1) ? r1_req : r0_req;
            end else begin
                if (!full && r0_req && m_sc < STARVE_MAX) win = 0;
                else if (!full && r1_req && (!r0_req || m_sc == STARVE_MAX)) win = 1;
                treq = (win >= 0);
            end
            e_wen   = !treq ? 64'd0 : (win == 1) ? 64'(r1_wen)   : 64'(r0_wen);
            e_strb  = !treq ? 64'd0 : (win == 1) ? 64'(r1_strb)  : 64'(r0_strb);
            e_addr  = !treq ? 64'd0 : (win == 1) ? 64'(r1_addr)  : 64'(r0_addr);
            e_wdata = !treq ? 64'd0 : (win == 1) ? r1_wdata : r0_wdata;
            e_gnt0 = t_gnt && treq && (win == 0);
            e_gnt1 = t_gnt && treq && (win == 1);
            head  = empty ? -1 : mq[0];
            e_ack = empty ? t_recv : ((head == 1) ? r1_ack : r0_ack);
            chk("t_req", t_req, treq);
            chk("t_wen", t_wen, e_wen);
            chk("t_strb", t_strb, e_strb);
            chk("t_addr", t_addr, e_addr);
            chk("t_wdata", t_wdata, e_wdata);
            chk("r0_gnt", r0_gnt, e_gnt0);
            chk("r1_gnt", r1_gnt, e_gnt1);
            chk("r0_recv", r0_recv, t_recv && head == 0);
            chk("r1_recv", r1_recv, t_recv && head == 1);
            chk("r0_error", r0_error, (head == 0) ? t_error : 1'b0);
            chk("r1_error", r1_error, (head == 1) ? t_error : 1'b0);
            chk("r0_rdata", r0_rdata, (head == 0) ? t_rdata : 64'd0);
            chk("r1_rdata", r1_rdata, (head == 1) ? t_rdata : 64'd0);
            chk("t_ack", t_ack, e_ack);
            chk("orphan_rsp", orphan_rsp, t_recv && empty);
            p_push = treq && t_gnt;
            p_pop = t_recv && e_ack && !empty;
            p_treq = treq;
            p_win = win;
            p_r1req = r1_req;
        end
    end

    // Model state update on the clock edge
    always @(posedge g_clk) begin
        if (g_reset) begin
            mq.delete();
            m_held = -1;
            m_sc = 0;
        end else begin
            if (p_pop) void'(mq.pop_front());
            if (p_push) begin
                mq.push_back(p_win);
                if (p_win == 1) m_sc = 0;
                else if (p_r1req && m_sc < STARVE_MAX) m_sc++;
                m_held = -1;
            end else if (m_held >= 0) begin
                if (!p_treq) m_held = -1;
            end else if (p_treq) begin
                m_held = p_win;
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 1'b0; r0_wen = 1'b0; r0_strb = '0; r0_addr = '0; r0_wdata = '0; r0_ack = 1'b0;
        r1_req = 1'b0; r1_wen = 1'b0; r1_strb = '0; r1_addr = '0; r1_wdata = '0; r1_ack = 1'b0;
        t_gnt = 1'b0; t_recv = 1'b0; t_error = 1'b0; t_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        g_reset = 1'b1;
        tick();
        tick();
        g_reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        #1;
        chk({nm, "_t_req"}, t_req, 1'b0);
        chk({nm, "_t_addr"}, t_addr, 64'd0);
        chk({nm, "_gnt"}, {r0_gnt, r1_gnt}, 2'b00);
        chk({nm, "_recv"}, {r0_recv, r1_recv}, 2'b00);
        chk({nm, "_t_ack"}, t_ack, 1'b0);
        chk({nm, "_orphan"}, orphan_rsp, 1'b0);
    endtask

    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        g_reset = 1'b1;
        idle_inputs();
        do_reset();
        chk_all_zero("reset");

        // Saturated contention: r1 wins every fifth grant
        r0_req = 1'b1; r0_addr = 39'h100; r1_req = 1'b1; r1_addr = 39'h200;
        t_gnt = 1'b1; t_recv = 1'b1; r0_ack = 1'b1; r1_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("starve_seq_r0", r0_gnt, exp_seq[i] == 0);
            chk("starve_seq_r1", r1_gnt, exp_seq[i] == 1);
            tick();
        end

        // Hold: r0 stalled three cycles, address stays put, then r1
        do_reset();
        r0_req = 1'b1; r0_addr = 39'h10000; r1_req = 1'b1; r1_addr = 39'h2000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_addr", t_addr, 64'h10000);
            chk("hold_no_gnt", r0_gnt, 1'b0);
            tick();
        end
        t_gnt = 1'b1;
        #1;
        chk("hold_addr4", t_addr, 64'h10000);
        chk("hold_r0_gnt", r0_gnt, 1'b1);
        tick();
        r0_req = 1'b0;
        #1;
        chk("after_hold_r1_gnt", r1_gnt, 1'b1);
        chk("after_hold_addr", t_addr, 64'h2000);
        tick();

        // Full FIFO blocks the third grant; response routes to r1
        do_reset();
        r1_req = 1'b1; r1_addr = 39'h300; t_gnt = 1'b1;
        #1; chk("full_r1_gnt", r1_gnt, 1'b1);
        tick();
        r1_req = 1'b0; r0_req = 1'b1; r0_addr = 39'h400;
        #1; chk("full_r0_gnt", r0_gnt, 1'b1);
        tick();
        r0_addr = 39'h500;
        #1; chk("full_t_req", t_req, 1'b0);
        tick();
        t_recv = 1'b1; t_rdata = 64'hDEAD; r1_ack = 1'b1;
        #1;
        chk("dead_r1_recv", r1_recv, 1'b1);
        chk("dead_r1_rdata", r1_rdata, 64'hDEAD);
        chk("dead_r0_recv", r0_recv, 1'b0);
        chk("dead_t_ack", t_ack, 1'b1);
        tick();
        t_recv = 1'b0; r1_ack = 1'b0;
        #1; chk("refill_r0_gnt", r0_gnt, 1'b1);
        tick();
        r0_req = 1'b0; t_gnt = 1'b0;

        // Error response to r0 with back-pressure
        t_recv = 1'b1; t_error = 1'b1; t_rdata = 64'hBEEF;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("err_r0_recv", r0_recv, 1'b1);
            chk("err_r0_error", r0_error, 1'b1);
            chk("err_t_ack_low", t_ack, 1'b0);
            tick();
        end
        r0_ack = 1'b1;
        #1; chk("err_t_ack", t_ack, 1'b1);
        tick();
        t_recv = 1'b0; t_error = 1'b0; r0_ack = 1'b0;

        // Reset while holding with one outstanding, then orphan drain
        r1_req = 1'b1; r1_addr = 39'h600;
        tick();
        #1; chk("pre_rst_hold_t_req", t_req, 1'b1);
        do_reset();
        chk_all_zero("mid_reset");
        t_recv = 1'b1; t_rdata = 64'h55;
        #1;
        chk("orphan", orphan_rsp, 1'b1);
        chk("orphan_t_ack", t_ack, 1'b1);
        chk("orphan_recv", {r0_recv, r1_recv}, 2'b00);
        tick();
        t_recv = 1'b0;
        #1; chk("orphan_pulse_end", orphan_rsp, 1'b0);
        r0_req = 1'b1; r1_req = 1'b1; t_gnt = 1'b1;
        #1;
        chk("restart_r0_gnt", r0_gnt, 1'b1);
        chk("restart_r1_gnt", r1_gnt, 1'b0);
        tick();

        // Randomised traffic checked only by the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (!r0_req || e_gnt0 || $urandom_range(0, 63) == 0) begin
                r0_req = ($urandom_range(0, 2) != 0);
                r0_wen = 1'($urandom); r0_strb = 8'($urandom);
                r0_addr = {7'($urandom), 32'($urandom)}; r0_wdata = {$urandom, $urandom};
            end
            if (!r1_req || e_gnt1 || $urandom_range(0, 63) == 0) begin
                r1_req = ($urandom_range(0, 2) != 0);
                r1_wen = 1'($urandom); r1_strb = 8'($urandom);
                r1_addr = {7'($urandom), 32'($urandom)}; r1_wdata = {$urandom, $urandom};
            end
            t_gnt = ($urandom_range(0, 3) != 0);
            t_recv = ($urandom_range(0, 2) == 0);
            t_error = 1'($urandom);
            t_rdata = {$urandom, $urandom};
            r0_ack = ($urandom_range(0, 2) != 0);
            r1_ack = ($urandom_range(0, 2) != 0);
            tick();
        end
        idle_inputs();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
